// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters, combinational lookup and resolve-time update.
// Optional statistics counters are compiled in when BPRED_STATS_EN is defined.
module branch_predictor #(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic        predTaken,
  output logic [31:0] predTarget,
  input  logic        resolveValid,
  input  logic [31:0] resolvePc,
  input  logic        resolveTaken,
  input  logic [31:0] resolveTarget,
  input  logic        resolvePredTaken,
  input  logic [31:0] resolvePredTarget,
  output logic        mispredict,
  output logic [31:0] redirectPc
`ifdef BPRED_STATS_EN
  ,
  output logic [31:0] statBranches,
  output logic [31:0] statMispredicts
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [31:0]      r_target [ENTRIES];
  logic [1:0]       r_ctr    [ENTRIES];

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_hit;
  logic [IDX_W-1:0] w_resIdx;
  logic [TAG_W-1:0] w_resTag;
  logic             w_resHit;
  logic             w_unused;

  assign w_idx    = pc[IDX_W+1:2];
  assign w_tag    = pc[31:IDX_W+2];
  assign w_resIdx = resolvePc[IDX_W+1:2];
  assign w_resTag = resolvePc[31:IDX_W+2];
  assign w_unused = ^{pc[1:0], resolvePc[1:0]};

  // Lookup reads the registered arrays only, so a same-cycle update is seen next cycle.
  assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign predTaken  = w_hit && r_ctr[w_idx][1];
  assign predTarget = predTaken ? r_target[w_idx] : pc + 32'd4;

  assign w_resHit   = r_valid[w_resIdx] && (r_tag[w_resIdx] == w_resTag);
  assign mispredict = resolveValid &&
                      ((resolveTaken != resolvePredTaken) ||
                       (resolveTaken && (resolveTarget != resolvePredTarget)));
  assign redirectPc = resolveTaken ? resolveTarget : resolvePc + 32'd4;

  // Tag and target are deliberately left unreset; valid=0 masks them.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= 2'b01;
      end
    end else if (resolveValid) begin
      if (w_resHit) begin
        if (resolveTaken) begin
          if (r_ctr[w_resIdx] != 2'b11) r_ctr[w_resIdx] <= r_ctr[w_resIdx] + 2'd1;
          r_target[w_resIdx] <= resolveTarget;
        end else if (r_ctr[w_resIdx] != 2'b00) begin
          r_ctr[w_resIdx] <= r_ctr[w_resIdx] - 2'd1;
        end
      end else if (resolveTaken) begin
        r_valid[w_resIdx]  <= 1'b1;
        r_tag[w_resIdx]    <= w_resTag;
        r_target[w_resIdx] <= resolveTarget;
        r_ctr[w_resIdx]    <= 2'b10;
      end
    end
  end

`ifdef BPRED_STATS_EN
  logic [31:0] r_statBranches;
  logic [31:0] r_statMispredicts;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_statBranches    <= 32'd0;
      r_statMispredicts <= 32'd0;
    end else begin
      if (resolveValid) r_statBranches <= r_statBranches + 32'd1;
      if (mispredict)   r_statMispredicts <= r_statMispredicts + 32'd1;
    end
  end

  assign statBranches    = r_statBranches;
  assign statMispredicts = r_statMispredicts;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized resolves
// compared against an array-based reference model of the BTB.
module tb_branch_predictor;

  localparam int ENTRIES = 16;
  localparam int IDX_W   = 4;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        predTaken;
  logic [31:0] predTarget;
  logic        resolveValid;
  logic [31:0] resolvePc;
  logic        resolveTaken;
  logic [31:0] resolveTarget;
  logic        resolvePredTaken;
  logic [31:0] resolvePredTarget;
  logic        mispredict;
  logic [31:0] redirectPc;
`ifdef BPRED_STATS_EN
  logic [31:0] statBranches;
  logic [31:0] statMispredicts;
`endif

  int tests    = 0;
  int failures = 0;

  // Reference model: one slot per index, counter kept as a plain integer 0..3.
  bit          mValid  [ENTRIES];
  int unsigned mTag    [ENTRIES];
  logic [31:0] mTarget [ENTRIES];
  int          mCtr    [ENTRIES];
  int unsigned mBranches;
  int unsigned mMispredicts;

  branch_predictor #(.ENTRIES(ENTRIES)) dut (
    .clk               (clk),
    .rst               (rst),
    .pc                (pc),
    .predTaken         (predTaken),
    .predTarget        (predTarget),
    .resolveValid      (resolveValid),
    .resolvePc         (resolvePc),
    .resolveTaken      (resolveTaken),
    .resolveTarget     (resolveTarget),
    .resolvePredTaken  (resolvePredTaken),
    .resolvePredTarget (resolvePredTarget),
    .mispredict        (mispredict),
    .redirectPc        (redirectPc)
`ifdef BPRED_STATS_EN
    ,
    .statBranches      (statBranches),
    .statMispredicts   (statMispredicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int mIdx(input logic [31:0] a);
    return int'((a / 4) % ENTRIES);
  endfunction

  function automatic int unsigned mTagOf(input logic [31:0] a);
    return int'(a / (4 * ENTRIES));
  endfunction

  function automatic bit modelHit(input logic [31:0] a);
    return mValid[mIdx(a)] && (mTag[mIdx(a)] == mTagOf(a));
  endfunction

  function automatic bit modelPredTaken(input logic [31:0] a);
    return modelHit(a) && (mCtr[mIdx(a)] >= 2);
  endfunction

  function automatic logic [31:0] modelPredTarget(input logic [31:0] a);
    return modelPredTaken(a) ? mTarget[mIdx(a)] : a + 32'd4;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < ENTRIES; i++) begin
      mValid[i] = 1'b0;
      mCtr[i]   = 1;
    end
    mBranches    = 0;
    mMispredicts = 0;
  endtask

  task automatic modelUpdate(input logic iRst, input logic iRv, input logic [31:0] iRpc,
                             input logic iRt, input logic [31:0] iRtgt, input bit iMis);
    int k;
    if (iRst) begin
      modelReset();
    end else if (iRv) begin
      k = mIdx(iRpc);
      mBranches++;
      if (iMis) mMispredicts++;
      if (modelHit(iRpc)) begin
        if (iRt) begin
          mCtr[k]    = (mCtr[k] + 1 > 3) ? 3 : mCtr[k] + 1;
          mTarget[k] = iRtgt;
        end else begin
          mCtr[k] = (mCtr[k] - 1 < 0) ? 0 : mCtr[k] - 1;
        end
      end else if (iRt) begin
        mValid[k]  = 1'b1;
        mTag[k]    = mTagOf(iRpc);
        mTarget[k] = iRtgt;
        mCtr[k]    = 2;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One cycle: drive at negedge, check combinational outputs, then advance the model at posedge.
  task automatic applyStimulus(input logic iRst, input logic [31:0] iPc, input logic iRv,
                               input logic [31:0] iRpc, input logic iRt, input logic [31:0] iRtgt,
                               input logic iRpt, input logic [31:0] iRptgt);
    bit          expMis;
    logic [31:0] expRedir;
    @(negedge clk);
    rst               = iRst;
    pc                = iPc;
    resolveValid      = iRv;
    resolvePc         = iRpc;
    resolveTaken      = iRt;
    resolveTarget     = iRtgt;
    resolvePredTaken  = iRpt;
    resolvePredTarget = iRptgt;
    #1;
    expMis   = iRv && ((iRt != iRpt) || (iRt && (iRtgt != iRptgt)));
    expRedir = iRt ? iRtgt : iRpc + 32'd4;
    checkOutput("predTaken", {31'd0, predTaken}, {31'd0, modelPredTaken(iPc)});
    checkOutput("predTarget", predTarget, modelPredTarget(iPc));
    checkOutput("mispredict", {31'd0, mispredict}, {31'd0, expMis});
    if (expMis) checkOutput("redirectPc", redirectPc, expRedir);
`ifdef BPRED_STATS_EN
    checkOutput("statBranches", statBranches, mBranches);
    checkOutput("statMispredicts", statMispredicts, mMispredicts);
`endif
    @(posedge clk);
    modelUpdate(iRst, iRv, iRpc, iRt, iRtgt, expMis);
  endtask

  initial begin
    logic [31:0] rpc;
    logic [31:0] lpc;
    logic [31:0] tgt;
    logic        rt;
    logic        rpt;
    logic [31:0] rptgt;

    rst = 1'b1; pc = 32'h0040_0010; resolveValid = 1'b0; resolvePc = 32'd0;
    resolveTaken = 1'b0; resolveTarget = 32'd0; resolvePredTaken = 1'b0; resolvePredTarget = 32'd0;
    repeat (2) @(posedge clk);
    modelReset();

    // Held in reset, then a cold lookup
    applyStimulus(1'b1, 32'h0040_0010, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    applyStimulus(1'b0, 32'h0040_0010, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    checkOutput("coldPredTarget", predTarget, 32'h0040_0014);

    // First taken resolve mispredicts and allocates; same-cycle lookup still sees the miss
    applyStimulus(1'b0, 32'h0040_0010, 1'b1, 32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0, 32'h0040_0014);
    applyStimulus(1'b0, 32'h0040_0010, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    checkOutput("allocTarget", predTarget, 32'h0040_0100);

    // Counter walk at one pc: 4 taken then 3 not-taken, lookup alongside each resolve
    for (int i = 0; i < 7; i++)
      applyStimulus(1'b0, 32'h0040_0020, 1'b1, 32'h0040_0020, (i < 4), 32'h0040_0300,
                    modelPredTaken(32'h0040_0020), modelPredTarget(32'h0040_0020));
    applyStimulus(1'b0, 32'h0040_0020, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    checkOutput("walkEndTaken", {31'd0, predTaken}, 32'd0);

    // Aliasing: new tag at the same index evicts the old entry
    applyStimulus(1'b0, 32'h0040_0050, 1'b1, 32'h0040_0050, 1'b1, 32'h0040_0200, 1'b0, 32'h0040_0054);
    applyStimulus(1'b0, 32'h0040_0010, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    checkOutput("aliasPredTarget", predTarget, 32'h0040_0014);

    // Same-cycle lookup and update at one index: old counter now, new counter next cycle
    applyStimulus(1'b0, 32'h0040_0050, 1'b1, 32'h0040_0050, 1'b0, 32'd0, 1'b1, 32'h0040_0200);
    applyStimulus(1'b0, 32'h0040_0050, 1'b1, 32'h0040_0050, 1'b0, 32'd0, 1'b1, 32'h0040_0200);
    applyStimulus(1'b0, 32'h0040_0050, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);

    // Randomized traffic over two tags and all indices
    for (int n = 0; n < 400; n++) begin
      rpc = ($urandom_range(0, 1) ? 32'h0080_0000 : 32'h0040_0000) + 32'($urandom_range(0, ENTRIES - 1) * 4);
      lpc = ($urandom_range(0, 1) ? 32'h0080_0000 : 32'h0040_0000) + 32'($urandom_range(0, ENTRIES - 1) * 4);
      if ($urandom_range(0, 3) == 0) lpc = rpc;
      tgt = 32'h0040_1000 + 32'($urandom_range(0, 3) * 16);
      rt  = 1'($urandom_range(0, 1));
      rpt   = modelPredTaken(rpc);
      rptgt = modelPredTarget(rpc);
      if ($urandom_range(0, 3) == 0) begin
        rpt   = 1'($urandom_range(0, 1));
        rptgt = $urandom;
      end
      applyStimulus(1'b0, lpc, 1'($urandom_range(0, 3) != 0), rpc, rt, tgt, rpt, rptgt);
    end

    // Mid-operation reset discards everything learned, even with a resolve in flight
    applyStimulus(1'b1, 32'h0040_0020, 1'b1, 32'h0040_0020, 1'b1, 32'h0040_0300, 1'b0, 32'd0);
    for (int i = 0; i < ENTRIES; i++)
      applyStimulus(1'b0, 32'h0040_0000 + 32'(i * 4), 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);

`ifdef BPRED_STATS_EN
    // Ten resolves, three of them mispredicted, then reset clears the counters
    applyStimulus(1'b1, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b0, 32'd0, 1'b1, 32'h0040_0080, 1'b0, 32'd0, (i < 3), 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    checkOutput("statBranches10", statBranches, 32'd10);
    checkOutput("statMispredicts3", statMispredicts, 32'd3);
    applyStimulus(1'b1, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    checkOutput("statBranchesRst", statBranches, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
